// File: rtl/io_addresses.sv
// Shared register map and clock-selection constants for the programmable timer.
// PROG_TIMER_K03_EN enables storage of clock-selection codes 000 and 001.
package io_addresses;

    localparam logic [2:0] AddrReloadLo = 3'd0;
    localparam logic [2:0] AddrReloadHi = 3'd1;
    localparam logic [2:0] AddrCountLo  = 3'd2;
    localparam logic [2:0] AddrCountHi  = 3'd3;
    localparam logic [2:0] AddrControl  = 3'd4;
    localparam logic [2:0] AddrClkSel   = 3'd5;
    localparam logic [2:0] AddrIrqMask  = 3'd6;
    localparam logic [2:0] AddrFactor   = 3'd7;

    // 256Hz tick source
    localparam logic [2:0] ClkSelReset  = 3'b010;

    function automatic logic [2:0] coerce_clk_sel(input logic [2:0] code);
`ifdef PROG_TIMER_K03_EN
        return code;
`else
        // Codes 000/001 select sources absent from this build
        return (code[2:1] == 2'b00) ? ClkSelReset : code;
`endif
    endfunction

endpackage

// File: rtl/clk_en_pulse.sv
// Holds a request until the next clk_en strobe has consumed it; requests that
// arrive while one is already pending are absorbed into the same pulse.
module clk_en_pulse (
    input  logic clk,
    input  logic reset,
    input  logic clk_en,
    input  logic set,
    output logic pulse
);

    logic pend_q, pend_d;

    always_comb begin
        pend_d = pend_q;
        if (pend_q) begin
            if (clk_en) begin
                pend_d = 1'b0;
            end
        end else if (set) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pulse = pend_q;

endmodule

// File: rtl/prog_timer_ctrl.sv
// Nibble-wide bus front end for the programmable timer: register file, atomic
// reload commit, count snapshot and strobe-aligned pulses. Macro: PROG_TIMER_K03_EN.
module prog_timer_ctrl
    import io_addresses::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_en,
    input  logic [2:0] bus_addr,
    input  logic [3:0] bus_wdata,
    input  logic       bus_wr,
    input  logic       bus_rd,
    output logic [3:0] bus_rdata,
    output logic       tmr_enable,
    output logic       tmr_reset,
    output logic [2:0] tmr_clock_selection,
    output logic [7:0] tmr_counter_reload,
    output logic       tmr_reset_factor,
    input  logic       tmr_factor_flags,
    input  logic [7:0] tmr_downcounter,
    output logic       irq
);

    logic       enable_q, enable_d;
    logic [7:0] reload_q, reload_d;
    logic [3:0] staging_q, staging_d;
    logic [2:0] clk_sel_q, clk_sel_d;
    logic       irq_mask_q, irq_mask_d;
    logic [3:0] snap_q, snap_d;
    logic [3:0] rdata_q, rdata_d;
    logic       rst_req, fac_req;
    logic       rd_en;

    // A simultaneous write wins; the read is dropped entirely
    assign rd_en = bus_rd & ~bus_wr;

    always_comb begin
        enable_d   = enable_q;
        reload_d   = reload_q;
        staging_d  = staging_q;
        clk_sel_d  = clk_sel_q;
        irq_mask_d = irq_mask_q;
        snap_d     = snap_q;
        rdata_d    = rdata_q;
        rst_req    = 1'b0;
        fac_req    = 1'b0;

        if (bus_wr) begin
            unique case (bus_addr)
                AddrReloadLo: staging_d  = bus_wdata;
                AddrReloadHi: reload_d   = {bus_wdata, staging_q};
                AddrControl: begin
                    enable_d = bus_wdata[0];
                    rst_req  = bus_wdata[1];
                end
                AddrClkSel:   clk_sel_d  = coerce_clk_sel(bus_wdata[2:0]);
                AddrIrqMask:  irq_mask_d = bus_wdata[0];
                default: ;
            endcase
        end

        if (rd_en) begin
            unique case (bus_addr)
                AddrReloadLo: rdata_d = staging_q;
                AddrReloadHi: rdata_d = reload_q[7:4];
                AddrCountLo: begin
                    rdata_d = tmr_downcounter[3:0];
                    snap_d  = tmr_downcounter[7:4];
                end
                AddrCountHi:  rdata_d = snap_q;
                AddrControl:  rdata_d = {3'b000, enable_q};
                AddrClkSel:   rdata_d = {1'b0, clk_sel_q};
                AddrIrqMask:  rdata_d = {3'b000, irq_mask_q};
                AddrFactor: begin
                    rdata_d = {3'b000, tmr_factor_flags};
                    fac_req = tmr_factor_flags;
                end
                default:      rdata_d = 4'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            enable_q   <= 1'b0;
            reload_q   <= 8'h00;
            staging_q  <= 4'h0;
            clk_sel_q  <= ClkSelReset;
            irq_mask_q <= 1'b0;
            snap_q     <= 4'h0;
            rdata_q    <= 4'h0;
        end else begin
            enable_q   <= enable_d;
            reload_q   <= reload_d;
            staging_q  <= staging_d;
            clk_sel_q  <= clk_sel_d;
            irq_mask_q <= irq_mask_d;
            snap_q     <= snap_d;
            rdata_q    <= rdata_d;
        end
    end

    clk_en_pulse u_reset_pulse (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .set    (rst_req),
        .pulse  (tmr_reset)
    );

    clk_en_pulse u_factor_pulse (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .set    (fac_req),
        .pulse  (tmr_reset_factor)
    );

    assign bus_rdata           = rdata_q;
    assign tmr_enable          = enable_q;
    assign tmr_clock_selection = clk_sel_q;
    assign tmr_counter_reload  = reload_q;
    assign irq                 = tmr_factor_flags & irq_mask_q;

endmodule

// File: tb/tb_prog_timer_ctrl.sv
// Scoreboard bench for prog_timer_ctrl: directed scenarios then random bus traffic,
// checked against a register-level reference model.
module tb_prog_timer_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clk_en = 1'b0;
    logic [2:0] bus_addr = '0;
    logic [3:0] bus_wdata = '0;
    logic       bus_wr = 1'b0;
    logic       bus_rd = 1'b0;
    logic [3:0] bus_rdata;
    logic       tmr_enable, tmr_reset, tmr_reset_factor, irq;
    logic [2:0] tmr_clock_selection;
    logic [7:0] tmr_counter_reload;
    logic       tmr_factor_flags = 1'b0;
    logic [7:0] tmr_downcounter = '0;

    prog_timer_ctrl dut (
        .clk                 (clk),
        .reset               (reset),
        .clk_en              (clk_en),
        .bus_addr            (bus_addr),
        .bus_wdata           (bus_wdata),
        .bus_wr              (bus_wr),
        .bus_rd              (bus_rd),
        .bus_rdata           (bus_rdata),
        .tmr_enable          (tmr_enable),
        .tmr_reset           (tmr_reset),
        .tmr_clock_selection (tmr_clock_selection),
        .tmr_counter_reload  (tmr_counter_reload),
        .tmr_reset_factor    (tmr_reset_factor),
        .tmr_factor_flags    (tmr_factor_flags),
        .tmr_downcounter     (tmr_downcounter),
        .irq                 (irq)
    );

    always #5 clk = ~clk;

`ifdef PROG_TIMER_K03_EN
    localparam bit K03 = 1'b1;
`else
    localparam bit K03 = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    // Reference model state
    logic [7:0] m_reload;
    logic [3:0] m_stage, m_snap;
    logic [2:0] m_clksel;
    logic       m_enable, m_mask, m_rst_pend, m_fac_pend;

    function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endfunction

    function automatic void model_reset();
        m_reload = 8'h00; m_stage = 4'h0; m_snap = 4'h0; m_clksel = 3'b010;
        m_enable = 1'b0; m_mask = 1'b0; m_rst_pend = 1'b0; m_fac_pend = 1'b0;
    endfunction

    // Monitor: every accepted read produces bus_rdata one edge later
    always begin
        logic fire;
        @(posedge clk);
        fire = bus_rd && !bus_wr && !reset;
        #2;
        if (fire) begin
            if (exp_q.size() == 0) begin
                chk("rdata_unexpected", 8'h01, 8'h00);
            end else begin
                chk("rdata", {4'h0, bus_rdata}, {4'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic check_outputs();
        chk("reload", tmr_counter_reload, m_reload);
        chk("enable", {7'b0, tmr_enable}, {7'b0, m_enable});
        chk("clksel", {5'b0, tmr_clock_selection}, {5'b0, m_clksel});
        chk("tmr_reset", {7'b0, tmr_reset}, {7'b0, m_rst_pend});
        chk("reset_factor", {7'b0, tmr_reset_factor}, {7'b0, m_fac_pend});
        chk("irq", {7'b0, irq}, {7'b0, tmr_factor_flags & m_mask});
    endtask

    // One bus cycle; model predicts the effect of the coming edge
    task automatic step(input logic en, input logic wr, input logic rd, input logic [2:0] addr,
                        input logic [3:0] wd, input logic fac, input logic [7:0] dc);
        logic rst_req, fac_req;
        logic [3:0] rv;
        clk_en = en; bus_wr = wr; bus_rd = rd; bus_addr = addr; bus_wdata = wd;
        tmr_factor_flags = fac; tmr_downcounter = dc;
        rst_req = 1'b0; fac_req = 1'b0;
        if (rd && !wr) begin
            case (addr)
                3'd0: rv = m_stage;
                3'd1: rv = m_reload[7:4];
                3'd2: begin rv = dc[3:0]; m_snap = dc[7:4]; end
                3'd3: rv = m_snap;
                3'd4: rv = {3'b0, m_enable};
                3'd5: rv = {1'b0, m_clksel};
                3'd6: rv = {3'b0, m_mask};
                default: begin rv = {3'b0, fac}; fac_req = fac; end
            endcase
            exp_q.push_back(rv);
        end
        if (wr) begin
            case (addr)
                3'd0: m_stage = wd;
                3'd1: m_reload = {wd, m_stage};
                3'd4: begin m_enable = wd[0]; rst_req = wd[1]; end
                3'd5: m_clksel = (!K03 && wd[2:1] == 2'b00) ? 3'b010 : wd[2:0];
                3'd6: m_mask = wd[0];
                default: ;
            endcase
        end
        // A pending pulse lasts until a strobe consumes it; new requests meanwhile merge
        m_rst_pend = m_rst_pend ? !en : rst_req;
        m_fac_pend = m_fac_pend ? !en : fac_req;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset(input logic en, input logic wr, input logic rd);
        reset = 1'b1; clk_en = en; bus_wr = wr; bus_rd = rd; bus_addr = 3'd4; bus_wdata = 4'b0011;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0; bus_wr = 1'b0; bus_rd = 1'b0;
        check_outputs();
        chk("rdata_reset", {4'h0, bus_rdata}, 8'h00);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset(1'b1, 1'b1, 1'b1);

        // Atomic reload commit
        step(1'b1, 1'b1, 1'b0, 3'd0, 4'hA, 1'b0, 8'h00);
        chk("reload_staged_only", tmr_counter_reload, 8'h00);
        step(1'b1, 1'b1, 1'b0, 3'd1, 4'h5, 1'b0, 8'h00);
        chk("reload_committed", tmr_counter_reload, 8'h5A);
        step(1'b0, 1'b0, 1'b1, 3'd0, 4'h0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 3'd1, 4'h0, 1'b0, 8'h00);

        // Count snapshot
        step(1'b0, 1'b0, 1'b1, 3'd2, 4'h0, 1'b0, 8'h3C);
        step(1'b0, 1'b0, 1'b1, 3'd3, 4'h0, 1'b0, 8'h2F);

        // Reset pulse held across idle cycles until a strobe
        step(1'b0, 1'b1, 1'b0, 3'd4, 4'b0011, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 8'h00);
        chk("tmr_reset_held", {7'b0, tmr_reset}, 8'h01);
        step(1'b1, 1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 8'h00);
        chk("tmr_reset_done", {7'b0, tmr_reset}, 8'h00);
        chk("enable_set", {7'b0, tmr_enable}, 8'h01);

        // Factor read and clear, irq masking
        step(1'b0, 1'b1, 1'b0, 3'd6, 4'h1, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b1, 3'd7, 4'h0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 1'b0, 3'd0, 4'h0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b1, 3'd7, 4'h0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 3'd0, 4'h0, 1'b1, 8'h00);

        // Write and read together: write wins, rdata holds
        step(1'b0, 1'b1, 1'b1, 3'd6, 4'h0, 1'b0, 8'h00);

        // Reset drops a pending pulse
        step(1'b0, 1'b1, 1'b0, 3'd4, 4'b0011, 1'b0, 8'h00);
        do_reset(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 8'h00);

        // Clock-selection coercion
        step(1'b0, 1'b1, 1'b0, 3'd5, 4'b0000, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 3'd5, 4'h0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 3'd5, 4'b0001, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 3'd5, 4'b0111, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 3'd5, 4'h0, 1'b0, 8'h00);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset(1'($urandom), 1'($urandom), 1'($urandom));
            end else begin
                step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0),
                     1'($urandom_range(0, 1)), 3'($urandom), 4'($urandom),
                     1'($urandom), 8'($urandom));
            end
        end

        step(1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 8'h00);
        chk("scoreboard_drained", 8'(exp_q.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_timer_ctrl.md
PROG_TIMER_CTRL -- requirements
Module: prog_timer_ctrl

Interface
REQ-001 SHALL have: clk  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: clk_en  in  1  CPU tick strobe; timer samples its inputs only when high.
REQ-004 SHALL have: bus_addr  in  3  register offset 0-7.
REQ-005 SHALL have: bus_wdata  in  4  write nibble; bus_wr  in  1  write strobe; bus_rd  in  1  read strobe.
REQ-006 SHALL have: bus_rdata  out  4  registered read nibble.
REQ-007 SHALL have: tmr_enable  out  1; tmr_reset  out  1; tmr_clock_selection  out  3; tmr_counter_reload  out  8; tmr_reset_factor  out  1.
REQ-008 SHALL have: tmr_factor_flags  in  1; tmr_downcounter  in  8.
REQ-009 SHALL have: irq  out  1  = tmr_factor_flags AND irq_mask.

Function
REQ-010 SHALL decode registers: 0 reload[3:0] RW; 1 reload[7:4] RW; 2 count[3:0] R; 3 count[7:4] R; 4 control {2'b0, reset W-only, enable}; 5 {0, clock_selection}; 6 {3'b0, irq_mask}; 7 {3'b0, factor} R.
REQ-011 SHALL stage writes to offset 0 in a staging nibble; a write to offset 1 SHALL commit {wdata, staging} to tmr_counter_reload in the same edge, giving an atomic 8-bit update.
REQ-012 SHALL return the staging nibble on reads of offset 0, and tmr_counter_reload[7:4] on reads of offset 1.
REQ-013 SHALL, on a read of offset 2, return tmr_downcounter[3:0] and snapshot tmr_downcounter[7:4] in the same edge; a read of offset 3 SHALL return the snapshot, never the live value.
REQ-014 SHALL present bus_rdata one cycle after bus_rd; it SHALL hold its value until the next read; unmapped or write-only bits SHALL read 0.
REQ-015 SHALL, on a write to offset 4 with bit1=1, set a reset-pending flag; tmr_reset SHALL equal that flag; the flag SHALL clear on the first edge with clk_en=1 after it is set, so the pulse always spans exactly one clk_en strobe.
REQ-016 SHALL, on a read of offset 7, return the current tmr_factor_flags and set a clear-pending flag only if that value was 1; tmr_reset_factor SHALL equal the flag, cleared as in REQ-015.
REQ-017 SHALL keep a read of offset 7 that returns 0 from scheduling a clear, so a factor that rises afterwards is not lost.
REQ-018 SHALL treat a repeated request while a flag is pending as a single pulse, with no queueing.
REQ-019 SHALL, when bus_wr and bus_rd are both high in one cycle, perform the write and ignore the read; bus_rdata SHALL then hold its previous value.
REQ-020 SHALL write enable (offset 4 bit0) directly to tmr_enable; setting bit1 together with bit0=1 SHALL arm reload and run from the same strobe.

Reset
REQ-021 SHALL, on reset, set: tmr_enable=0, tmr_reset=0, tmr_reset_factor=0, pending flags=0, irq_mask=0, staging=0, snapshot=0, bus_rdata=0.
REQ-022 SHALL, on reset, set tmr_counter_reload=8'h00 and tmr_clock_selection=3'b010 (256Hz).
REQ-023 SHALL give reset priority over simultaneous bus strobes and pending pulses; a pulse that is pending when reset asserts SHALL be dropped.

Configuration
REQ-024 SHALL honour macro PROG_TIMER_K03_EN; when it is defined, clock_selection SHALL store all 8 codes.
REQ-025 SHALL, when PROG_TIMER_K03_EN is undefined, coerce writes of code 000 or 001 to 010 and read back the coerced value.

Structure
REQ-026 SHALL take the register offsets (8 localparams) and the reset clock-selection constant from shared package io_addresses.
REQ-027 SHALL implement REQ-015/016 with one sub-module, clk_en_pulse (set, clk_en -> held one-strobe pulse), instantiated twice.

Verification
REQ-028 SHALL cover: write off0=4'hA, then off1=4'h5 -> tmr_counter_reload goes 8'h00 to 8'h5A only at the off1 write edge.
REQ-029 SHALL cover: downcounter=8'h3C; read off2, change downcounter to 8'h2F, read off3 -> reads 4'hC then 4'h3.
REQ-030 SHALL cover: write off4=4'b0011 with clk_en low for 5 cycles -> tmr_reset high for those 5 cycles and through the first clk_en edge, then low; tmr_enable=1.
REQ-031 SHALL cover: factor=1, mask=1, irq=1; read off7 -> rdata=1, tmr_reset_factor for one strobe; read with factor=0 -> no pulse.
REQ-032 SHALL cover: reset asserted while a reset pulse is pending -> all outputs take REQ-021/022 values on the next edge, with no pulse afterwards.
REQ-033 SHALL cover: write off5=3'b000 -> reads back 000 with PROG_TIMER_K03_EN defined, 010 without it.
